// File: rtl/hazard_unit_mdu.sv
// Hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W), Tuse/Tnew based.
// Ports:
//   clk, reset (async, active-low)
//   rs_D/rt_D, tuse_rs_D/tuse_rt_D   : D-stage sources and their consumption time
//   rs_E/rt_E, rt_M                  : later-stage sources needing forwarding
//   wa_E/wa_M/wa_W, tnew_E/tnew_M    : in-flight destinations and their readiness
//   md_use_D, md_start_E, md_is_div_E: multiply/divide unit control
//   stall, flush_E                   : combinational pipeline freeze / bubble
//   fwd_*                            : combinational forwarding selects
//   md_busy, stall_count             : MDU occupancy and saturating stall counter
module hazard_unit_mdu #(
    parameter int unsigned AW          = 5,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rs_D,
    input  logic [AW-1:0]     rt_D,
    input  logic [1:0]        tuse_rs_D,
    input  logic [1:0]        tuse_rt_D,
    input  logic [AW-1:0]     rs_E,
    input  logic [AW-1:0]     rt_E,
    input  logic [AW-1:0]     rt_M,
    input  logic [AW-1:0]     wa_E,
    input  logic [AW-1:0]     wa_M,
    input  logic [AW-1:0]     wa_W,
    input  logic [1:0]        tnew_E,
    input  logic              tnew_M,
    input  logic              md_use_D,
    input  logic              md_start_E,
    input  logic              md_is_div_E,
    output logic              stall,
    output logic              flush_E,
    output logic [1:0]        fwd_rs_D,
    output logic [1:0]        fwd_rt_D,
    output logic [1:0]        fwd_rs_E,
    output logic [1:0]        fwd_rt_E,
    output logic              fwd_rt_M,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_count
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0]     r_md_cnt;
    logic [PERF_W-1:0] r_stall_cnt;
    logic              w_stall_rs;
    logic              w_stall_rt;
    logic              w_stall_md;
    logic              w_stall;

    // Stall when the producer's result arrives later than the consumer needs it.
    function automatic logic src_stall(input logic [AW-1:0] a, input logic [1:0] tuse,
                                       input logic [AW-1:0] we, input logic [1:0] tne,
                                       input logic [AW-1:0] wm, input logic tnm);
        logic hit_e;
        logic hit_m;
        hit_e = (a == we) && (tuse < tne);
        hit_m = (a == wm) && (tuse < {1'b0, tnm});
        return (a != '0) && (hit_e || hit_m);
    endfunction

    // D-stage select: a matching but unready nearer stage blocks older stages.
    function automatic logic [1:0] fwd_d(input logic [AW-1:0] a,
                                         input logic [AW-1:0] we, input logic [1:0] tne,
                                         input logic [AW-1:0] wm, input logic tnm,
                                         input logic [AW-1:0] ww);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != '0) begin
            if (a == we)      sel = (tne == 2'd0) ? 2'd1 : 2'd0;
            else if (a == wm) sel = (!tnm) ? 2'd2 : 2'd0;
            else if (a == ww) sel = 2'd3;
        end
        return sel;
    endfunction

    // E-stage select, same nearest-producer rule over M and W.
    function automatic logic [1:0] fwd_e(input logic [AW-1:0] a,
                                         input logic [AW-1:0] wm, input logic tnm,
                                         input logic [AW-1:0] ww);
        logic [1:0] sel;
        sel = 2'd0;
        if (a != '0) begin
            if (a == wm)      sel = (!tnm) ? 2'd1 : 2'd0;
            else if (a == ww) sel = 2'd2;
        end
        return sel;
    endfunction

    // Combinational stall/flush and forwarding selects.
    always_comb begin
        w_stall_rs = src_stall(rs_D, tuse_rs_D, wa_E, tnew_E, wa_M, tnew_M);
        w_stall_rt = src_stall(rt_D, tuse_rt_D, wa_E, tnew_E, wa_M, tnew_M);
        w_stall_md = md_use_D && ((r_md_cnt != '0) || md_start_E);
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    end

    assign stall    = w_stall;
    assign flush_E  = w_stall;
    assign fwd_rs_D = fwd_d(rs_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
    assign fwd_rt_D = fwd_d(rt_D, wa_E, tnew_E, wa_M, tnew_M, wa_W);
    assign fwd_rs_E = fwd_e(rs_E, wa_M, tnew_M, wa_W);
    assign fwd_rt_E = fwd_e(rt_E, wa_M, tnew_M, wa_W);
    assign fwd_rt_M = (rt_M != '0) && (rt_M == wa_W);

    // MDU busy counter; a new start always reloads (last start wins).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (md_start_E) begin
            r_md_cnt <= md_is_div_E ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end

    assign md_busy = (r_md_cnt != '0);

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Directed bench for hazard_unit_mdu; stall counter narrowed to 4 bits to reach saturation.
module tb_hazard_unit_mdu;

    localparam int unsigned AW = 5;
    localparam int unsigned PW = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rs_D, rt_D, rs_E, rt_E, rt_M, wa_E, wa_M, wa_W;
    logic [1:0]    tuse_rs_D, tuse_rt_D, tnew_E;
    logic          tnew_M, md_use_D, md_start_E, md_is_div_E;
    logic          stall, flush_E, fwd_rt_M, md_busy;
    logic [1:0]    fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic [PW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_unit_mdu #(.AW(AW), .MULT_CYCLES(5), .DIV_CYCLES(10), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
        .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
        .wa_E(wa_E), .wa_M(wa_M), .wa_W(wa_W), .tnew_E(tnew_E), .tnew_M(tnew_M),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .stall(stall), .flush_E(flush_E),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .fwd_rt_M(fwd_rt_M), .md_busy(md_busy), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0; rt_M = '0;
        wa_E = '0; wa_M = '0; wa_W = '0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = 2'd0; tnew_M = 1'b0;
        md_use_D = 1'b0; md_start_E = 1'b0; md_is_div_E = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_busy", 32'(md_busy), 32'd0);
        check("reset_count", 32'(stall_count), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        @(negedge clk) reset = 1'b1;

        // lw $1 in E, addu in D uses rs=1 at E
        @(negedge clk);
        rs_D = 5'd1; tuse_rs_D = 2'd1; wa_E = 5'd1; tnew_E = 2'd2; #1;
        check("lw_use_stall", 32'(stall), 32'd1);
        check("lw_use_flush", 32'(flush_E), 32'd1);
        @(negedge clk);
        wa_E = '0; tnew_E = 2'd0; wa_M = 5'd1; tnew_M = 1'b1; #1;
        check("lw_in_M_nostall", 32'(stall), 32'd0);
        @(negedge clk);
        clear_inputs(); rs_E = 5'd1; wa_W = 5'd1; #1;
        check("lw_W_fwd_rs_E", 32'(fwd_rs_E), 32'd2);

        // beq needs rs at D; ALU result one cycle away
        @(negedge clk);
        clear_inputs(); rs_D = 5'd3; tuse_rs_D = 2'd0; wa_E = 5'd3; tnew_E = 2'd1; #1;
        check("beq_alu_stall", 32'(stall), 32'd1);
        @(negedge clk);
        wa_E = '0; tnew_E = 2'd0; wa_M = 5'd3; tnew_M = 1'b0; #1;
        check("beq_M_nostall", 32'(stall), 32'd0);
        check("beq_M_fwd_rs_D", 32'(fwd_rs_D), 32'd2);

        // jal in E, jr $31 in D takes PC+8 from E
        @(negedge clk);
        clear_inputs(); rs_D = 5'd31; tuse_rs_D = 2'd0; wa_E = 5'd31; tnew_E = 2'd0; #1;
        check("jal_jr_nostall", 32'(stall), 32'd0);
        check("jal_jr_fwd_rs_D", 32'(fwd_rs_D), 32'd1);

        // unready E match must not fall through to ready M
        @(negedge clk);
        clear_inputs(); rs_D = 5'd5; tuse_rs_D = 2'd1; wa_E = 5'd5; tnew_E = 2'd2;
        wa_M = 5'd5; tnew_M = 1'b0; #1;
        check("shadow_fwd_rs_D", 32'(fwd_rs_D), 32'd0);
        check("shadow_stall", 32'(stall), 32'd1);

        // rt timing boundaries and W forwarding
        @(negedge clk);
        clear_inputs(); rt_D = 5'd7; tuse_rt_D = 2'd2; wa_E = 5'd7; tnew_E = 2'd2; #1;
        check("rt_tuse2_tnew2", 32'(stall), 32'd0);
        tuse_rt_D = 2'd1; #1;
        check("rt_tuse1_tnew2", 32'(stall), 32'd1);
        tuse_rt_D = 2'd3; #1;
        check("rt_tuse3", 32'(stall), 32'd0);
        wa_E = '0; wa_W = 5'd7; #1;
        check("rt_fwd_W_D", 32'(fwd_rt_D), 32'd3);

        // register zero never stalls or forwards
        @(negedge clk);
        clear_inputs(); tuse_rs_D = 2'd0; tnew_E = 2'd2; tnew_M = 1'b1; #1;
        check("zero_stall", 32'(stall), 32'd0);
        check("zero_fwd_all",
              32'({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}), 32'd0);
        @(negedge clk);
        clear_inputs(); wa_M = 5'd4; wa_W = 5'd4; rt_E = 5'd4; tnew_M = 1'b0; #1;
        check("rt_E_fwd_M", 32'(fwd_rt_E), 32'd1);
        tnew_M = 1'b1; #1;
        check("rt_E_M_notready", 32'(fwd_rt_E), 32'd0);
        rt_M = 5'd4; #1;
        check("rt_M_fwd_W", 32'(fwd_rt_M), 32'd1);
        rt_M = 5'd9; #1;
        check("rt_M_nomatch", 32'(fwd_rt_M), 32'd0);

        // MDU user with idle MDU
        @(negedge clk);
        clear_inputs(); md_use_D = 1'b1; #1;
        check("md_idle_nostall", 32'(stall), 32'd0);

        // restart counting from zero
        @(negedge clk);
        clear_inputs(); reset = 1'b0; #1; reset = 1'b1;
        check("count_cleared", 32'(stall_count), 32'd0);

        // div start, then mflo held in D
        @(negedge clk);
        md_use_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b1; #1;
        check("div_start_stall", 32'(stall), 32'd1);
        check("div_start_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        md_start_E = 1'b0; md_is_div_E = 1'b0; #1;
        check("div_busy1", 32'(md_busy), 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("div_busy_last", 32'(md_busy), 32'd1);
        check("div_stall_last", 32'(stall), 32'd1);
        check("div_count10", 32'(stall_count), 32'd10);
        @(negedge clk);
        check("div_busy_done", 32'(md_busy), 32'd0);
        check("div_stall_done", 32'(stall), 32'd0);
        check("div_count11", 32'(stall_count), 32'd11);

        // saturate the 4-bit stall counter
        clear_inputs(); rs_D = 5'd1; tuse_rs_D = 2'd1; wa_E = 5'd1; tnew_E = 2'd2;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("count_sat15", 32'(stall_count), 32'd15);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("count_hold15", 32'(stall_count), 32'd15);

        // async reset in the middle of a div
        clear_inputs(); md_start_E = 1'b1; md_is_div_E = 1'b1;
        @(negedge clk);
        md_start_E = 1'b0; md_is_div_E = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_busy_pre", 32'(md_busy), 32'd1);
        #2 reset = 1'b0;
        rs_D = 5'd1; tuse_rs_D = 2'd1; wa_E = 5'd1; tnew_E = 2'd2;
        #1;
        check("mid_reset_busy", 32'(md_busy), 32'd0);
        check("mid_reset_count", 32'(stall_count), 32'd0);
        check("reset_comb_stall", 32'(stall), 32'd1);
        #1 reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
